// File: rtl/lsu_mem_if.sv
// Memory-stage load/store unit: turns EX/MEM load/store requests into
// valid/ready data-bus transactions and returns aligned, extended load data.
// The pipeline is held while a transaction is in flight. Misaligned accesses
// and response timeouts are reported as single-cycle pulses.

package lsu_pkg;
    typedef enum logic [3:0] {
        LSU_NOP,
        LSU_LB,
        LSU_LH,
        LSU_LW,
        LSU_LBU,
        LSU_LHU,
        LSU_SB,
        LSU_SH,
        LSU_SW
    } lsuCtrl_e;
endpackage

module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  lsuCtrl_e    lsu_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [3:0]  req_wstrb,
    output logic [31:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_e;

    // The counter only has to reach RSP_TIMEOUT-1; when the timeout is
    // disabled it simply wraps and is never compared.
    localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RSP_TIMEOUT - 1);

    state_e           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    lsuCtrl_e         op_reg;
    logic [1:0]       off_reg;

    logic        is_load;
    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        op_valid;
    logic        misaligned;
    logic [3:0]  wstrb_next;
    logic [31:0] wdata_next;
    logic [31:0] shifted;
    logic [31:0] extracted;

    assign is_load    = lsu_ctrl inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
    assign is_store   = lsu_ctrl inside {LSU_SB, LSU_SH, LSU_SW};
    assign is_half    = lsu_ctrl inside {LSU_LH, LSU_LHU, LSU_SH};
    assign is_word    = lsu_ctrl inside {LSU_LW, LSU_SW};
    assign op_valid   = is_load || is_store;
    assign misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));

    // Stall and the misalign flag are combinational so the pipeline reacts in
    // the same cycle; both are forced low while reset is held.
    assign stall = rst_n && (((state_reg == S_IDLE) && op_valid && !misaligned) ||
                             (state_reg == S_REQ) || (state_reg == S_RSP));
    assign misalign_err = rst_n && (state_reg == S_IDLE) && misaligned;

    // Replicate the store operand across byte lanes so any enabled lane
    // carries the right byte regardless of offset.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_next[gi*8 +: 8] =
            (lsu_ctrl == LSU_SB) ? store_data[7:0] :
            (lsu_ctrl == LSU_SH) ? store_data[(gi % 2)*8 +: 8] :
                                   store_data[gi*8 +: 8];
    end

    // Byte enables for the captured store; loads carry no strobes.
    always_comb begin
        wstrb_next = 4'b0000;
        case (lsu_ctrl)
            LSU_SB:  wstrb_next = 4'b0001 << addr[1:0];
            LSU_SH:  wstrb_next = 4'b0011 << addr[1:0];
            LSU_SW:  wstrb_next = 4'b1111;
            default: wstrb_next = 4'b0000;
        endcase
    end

    // Move the addressed bytes to the bottom of the word and extend them
    // according to the captured load type.
    assign shifted = rsp_rdata >> {off_reg, 3'b000};

    always_comb begin
        extracted = shifted;
        case (op_reg)
            LSU_LB:  extracted = {{24{shifted[7]}}, shifted[7:0]};
            LSU_LBU: extracted = {24'h0, shifted[7:0]};
            LSU_LH:  extracted = {{16{shifted[15]}}, shifted[15:0]};
            LSU_LHU: extracted = {16'h0, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

    // Transaction sequencer with registered bus and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            op_reg    <= LSU_NOP;
            off_reg   <= 2'b00;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= 32'h0;
            req_wstrb <= 4'h0;
            req_wdata <= 32'h0;
            load_data <= 32'h0;
            done      <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            bus_err <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (op_valid && !misaligned) begin
                        req_valid <= 1'b1;
                        req_we    <= is_store;
                        req_addr  <= {addr[31:2], 2'b00};
                        req_wstrb <= wstrb_next;
                        req_wdata <= wdata_next;
                        op_reg    <= lsu_ctrl;
                        off_reg   <= addr[1:0];
                        state_reg <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        if (req_we) begin
                            // Writes are posted: no response is awaited.
                            done      <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            cnt_reg   <= '0;
                            state_reg <= S_RSP;
                        end
                    end
                end
                S_RSP: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (rsp_valid) begin
                        load_data <= extracted;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end else if ((RSP_TIMEOUT != 0) && (cnt_reg == TO_LAST)) begin
                        load_data <= 32'h0;
                        bus_err   <= 1'b1;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                default: begin
                    // DONE: inputs are ignored so the finished op is not reissued.
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Testbench for lsu_mem_if: directed scenarios followed by randomized loads
// and stores, checked against a byte-lane reference model.

module tb_lsu_mem_if;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    lsuCtrl_e    lsu_ctrl;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        done;
    logic        misalign_err;
    logic        bus_err;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int errors = 0;
    bit in_done = 0;

    lsu_mem_if #(.RSP_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lsu_ctrl     (lsu_ctrl),
        .addr         (addr),
        .store_data   (store_data),
        .stall        (stall),
        .load_data    (load_data),
        .done         (done),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wstrb    (req_wstrb),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void decode(input lsuCtrl_e op, output int size, output bit ld, output bit sgn);
        size = 4; ld = 0; sgn = 0;
        case (op)
            LSU_LB:  begin size = 1; ld = 1; sgn = 1; end
            LSU_LBU: begin size = 1; ld = 1; end
            LSU_LH:  begin size = 2; ld = 1; sgn = 1; end
            LSU_LHU: begin size = 2; ld = 1; end
            LSU_LW:  begin size = 4; ld = 1; end
            LSU_SB:  size = 1;
            LSU_SH:  size = 2;
            default: size = 4;
        endcase
    endfunction

    // Reference load result: pick the addressed bytes, then extend.
    function automatic logic [31:0] model_load(input int size, input bit sgn, input int off, input logic [31:0] w);
        logic [31:0] v;
        logic [31:0] mask;
        v = w >> (off * 8);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (size * 8)) - 32'd1);
        v = v & mask;
        if (sgn && v[size*8-1]) v = v | ~mask;
        return v;
    endfunction

    // Run one aligned op to its DONE cycle, acting as the bus slave.
    task automatic do_op(input lsuCtrl_e op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdata, input int rdy_dly, input int rsp_dly,
                         input bit give_rsp);
        int size, off, exp_stalls, stalls, req_cyc, rsp_cyc;
        bit ld, sgn, accepted, finished;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata, exp_load;
        decode(op, size, ld, sgn);
        off = int'(a[1:0]);
        exp_strb = ld ? 4'b0000 : 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = sd[8*(i % size) +: 8];
        exp_load = give_rsp ? model_load(size, sgn, off, rdata) : 32'h0;
        if (!ld)           exp_stalls = 2 + rdy_dly;
        else if (give_rsp) exp_stalls = 3 + rdy_dly + rsp_dly;
        else               exp_stalls = 2 + rdy_dly + TO;
        stalls = 0; req_cyc = 0; rsp_cyc = 0; accepted = 0; finished = 0;

        lsu_ctrl = op; addr = a; store_data = sd; req_ready = 0; rsp_valid = 0;
        if (in_done) begin
            #1;
            check("done_cycle_stall", {31'h0, stall}, 32'h0);
            @(negedge clk);
            in_done = 0;
        end
        for (int c = 0; c < 40 && !finished; c++) begin
            #1;
            req_ready = 0;
            rsp_valid = 0;
            if (done) begin
                finished = 1;
                check("done_stall", {31'h0, stall}, 32'h0);
                check("done_req_valid", {31'h0, req_valid}, 32'h0);
                check("done_bus_err", {31'h0, bus_err}, {31'h0, ld && !give_rsp});
                check("stall_cycles", stalls, exp_stalls);
                if (ld) check("load_data", load_data, exp_load);
                lsu_ctrl = LSU_NOP;
            end else begin
                if (stall) stalls++;
                if (c == 0) begin
                    check("capture_stall", {31'h0, stall}, 32'h1);
                    check("capture_req_valid", {31'h0, req_valid}, 32'h0);
                end else if (!accepted) begin
                    check("req_valid", {31'h0, req_valid}, 32'h1);
                    check("req_addr", req_addr, a & 32'hFFFF_FFFC);
                    check("req_we", {31'h0, req_we}, {31'h0, !ld});
                    check("req_wstrb", {28'h0, req_wstrb}, {28'h0, exp_strb});
                    if (!ld) check("req_wdata", req_wdata, exp_wdata);
                    if (req_cyc == rdy_dly) begin
                        req_ready = 1;
                        accepted = 1;
                    end
                    req_cyc++;
                end else begin
                    check("rsp_req_valid", {31'h0, req_valid}, 32'h0);
                    rsp_rdata = $urandom;
                    if (give_rsp && rsp_cyc == rsp_dly) begin
                        rsp_valid = 1;
                        rsp_rdata = rdata;
                    end
                    rsp_cyc++;
                end
                @(negedge clk);
            end
        end
        if (!finished) check("op_completed", 32'h0, 32'h1);
        $display("op %s addr=%h sd=%h rdy=%0d rsp=%0d give_rsp=%0d stalls=%0d load_data=%h bus_err=%0d",
                 op.name(), a, sd, rdy_dly, rsp_dly, give_rsp, stalls, load_data, bus_err);
        in_done = 1;
    endtask

    // The cycle after DONE: back in IDLE with no op presented.
    task automatic idle_check();
        @(negedge clk);
        #1;
        check("post_done", {31'h0, done}, 32'h0);
        check("post_stall", {31'h0, stall}, 32'h0);
        check("post_bus_err", {31'h0, bus_err}, 32'h0);
        in_done = 0;
    endtask

    task automatic misalign_op(input lsuCtrl_e op, input logic [31:0] a);
        lsu_ctrl = op; addr = a; store_data = $urandom;
        #1;
        check("misalign_err", {31'h0, misalign_err}, 32'h1);
        check("misalign_stall", {31'h0, stall}, 32'h0);
        check("misalign_req_valid", {31'h0, req_valid}, 32'h0);
        lsu_ctrl = LSU_NOP;
        @(negedge clk);
        #1;
        check("misalign_clear", {31'h0, misalign_err}, 32'h0);
        check("misalign_no_req", {31'h0, req_valid}, 32'h0);
        check("misalign_no_done", {31'h0, done}, 32'h0);
        $display("misaligned %s addr=%h misalign_err pulse observed", op.name(), a);
    endtask

    initial begin
        lsuCtrl_e    op;
        int          size;
        bit          ld, sgn;
        logic [31:0] a;

        rst_n = 1; lsu_ctrl = LSU_SW; addr = 32'h1; store_data = 0;
        req_ready = 0; rsp_valid = 0; rsp_rdata = 0;
        #2 rst_n = 0;
        #1;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_misalign", {31'h0, misalign_err}, 32'h0);
        check("rst_req_valid", {31'h0, req_valid}, 32'h0);
        check("rst_req_we", {31'h0, req_we}, 32'h0);
        check("rst_req_addr", req_addr, 32'h0);
        check("rst_req_wstrb", {28'h0, req_wstrb}, 32'h0);
        check("rst_req_wdata", req_wdata, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_bus_err", {31'h0, bus_err}, 32'h0);
        $display("reset state checked");
        lsu_ctrl = LSU_NOP; addr = 0;
        @(negedge clk); @(negedge clk); #1;
        rst_n = 1;

        // 1: byte store at the top lane
        do_op(LSU_SB, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 1);
        idle_check();
        // 2: signed then unsigned byte load, issued back to back
        do_op(LSU_LB,  32'h0000_2002, 32'h0, 32'h12F0_3456, 0, 0, 1);
        do_op(LSU_LBU, 32'h0000_2002, 32'h0, 32'h12F0_3456, 0, 0, 1);
        idle_check();
        // 3: misaligned half and word
        misalign_op(LSU_LH, 32'h0000_3001);
        misalign_op(LSU_LW, 32'h0000_3002);
        // 4: word store held off by the bus for 5 cycles
        do_op(LSU_SW, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0, 5, 0, 1);
        idle_check();
        // 5: load with no response times out; a late response is ignored
        do_op(LSU_LW, 32'h0000_5000, 32'h0, 32'h0, 0, 0, 0);
        idle_check();
        rsp_valid = 1; rsp_rdata = 32'hCAFE_F00D;
        @(negedge clk); #1;
        rsp_valid = 0;
        check("late_rsp_done", {31'h0, done}, 32'h0);
        check("late_rsp_stall", {31'h0, stall}, 32'h0);
        check("late_rsp_load_data", load_data, 32'h0);
        $display("late response after timeout ignored");

        // 6: reset while waiting for a read response
        lsu_ctrl = LSU_LW; addr = 32'h0000_6000; req_ready = 0; rsp_valid = 0;
        @(negedge clk); #1;
        req_ready = 1;
        @(negedge clk); #1;
        req_ready = 0;
        check("t6_rsp_stall", {31'h0, stall}, 32'h1);
        rst_n = 0;
        #1;
        check("t6_rst_req_valid", {31'h0, req_valid}, 32'h0);
        check("t6_rst_stall", {31'h0, stall}, 32'h0);
        check("t6_rst_done", {31'h0, done}, 32'h0);
        lsu_ctrl = LSU_NOP;
        @(negedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            rsp_valid = 1; rsp_rdata = $urandom;
            @(negedge clk); #1;
            check("t6_stale_done", {31'h0, done}, 32'h0);
            check("t6_stale_stall", {31'h0, stall}, 32'h0);
            check("t6_stale_load_data", load_data, 32'h0);
        end
        rsp_valid = 0;
        $display("reset during response wait dropped the load");
        do_op(LSU_SW, 32'h0000_6004, 32'h1234_5678, 32'h0, 1, 0, 1);

        // Randomized mix of loads and stores with random bus timing
        for (int n = 0; n < 60; n++) begin
            op = lsuCtrl_e'($urandom_range(1, 8));
            decode(op, size, ld, sgn);
            a = $urandom;
            if (size == 2) a[0] = 1'b0;
            if (size == 4) a[1:0] = 2'b00;
            if (size > 1 && $urandom_range(0, 5) == 0) begin
                a[0] = 1'b1;
                if (in_done) idle_check();
                misalign_op(op, a);
            end else begin
                if (in_done && $urandom_range(0, 1) == 0) idle_check();
                do_op(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 7) != 0);
            end
        end
        if (in_done) idle_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
